uart_cfg: RTL

Runtime-configurable 16x-oversampled UART with one TX and one RX channel. It sits between CPU-side peripheral registers and the board serial pins and shares one fractional baud generator between both directions. Frame format is selectable per frame: 5–8 data bits, optional even/odd parity, and 1 or 2 stop bits. Data moves through a ready/valid TX handshake and a pulsed RX output with parity and framing error flags.

---
 rtl/uart_cfg.sv | 289 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_cfg.sv
// uart_cfg: 16x-oversampled UART (one TX, one RX) with per-frame format and a shared fractional baud generator.
// Build option: define UART_CFG_PARITY_EN to include parity generation and checking.
module uart_cfg #(
    parameter int ACC_W = 12,
    parameter int ADD_W = 11
) (
    input  logic             CLK_I,
    input  logic             RESET_I,
    input  logic [ADD_W-1:0] ADD_I,
    input  logic [1:0]       CFG_BITS_I,
    input  logic [1:0]       CFG_PAR_I,
    input  logic             CFG_STOP2_I,
    input  logic [7:0]       TX_DATA_I,
    input  logic             TX_VALID_I,
    output logic             TX_READY_O,
    output logic             TX_O,
    input  logic             RX_I,
    output logic [7:0]       RX_DATA_O,
    output logic             RX_VALID_O,
    output logic             RX_PERR_O,
    output logic             RX_FERR_O
);

    typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP1, T_STOP2} tx_state_t;
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_BRK} rx_state_t;

    logic [ACC_W:0] acc;
    logic           tick16;
    logic           cfg_par_en;
    logic           cfg_par_odd;

    always_ff @(posedge CLK_I or posedge RESET_I) begin
        if (RESET_I) acc <= '0;
        else         acc <= {1'b0, acc[ACC_W-1:0]} + {{(ACC_W + 1 - ADD_W){1'b0}}, ADD_I};
    end
    assign tick16 = acc[ACC_W];

`ifdef UART_CFG_PARITY_EN
    assign cfg_par_en  = CFG_PAR_I[1];
    assign cfg_par_odd = CFG_PAR_I[0];
`else
    logic unused_par;
    assign cfg_par_en  = 1'b0;
    assign cfg_par_odd = 1'b0;
    assign unused_par  = ^CFG_PAR_I;
`endif

    // ---------------- transmitter ----------------
    tx_state_t  tx_state, tx_state_n;
    logic [3:0] tx_sub, tx_sub_n;
    logic [2:0] tx_idx, tx_idx_n;
    logic [2:0] tx_last, tx_last_n;
    logic [7:0] tx_data, tx_data_n;
    logic       tx_par_en, tx_par_en_n;
    logic       tx_par_odd, tx_par_odd_n;
    logic       tx_stop2, tx_stop2_n;
    logic       tx_bit_end;
    logic       tx_line_d;
    logic       tx_ready_d;

    assign tx_bit_end = tick16 && (tx_sub == 4'd15);

    always_ff @(posedge CLK_I or posedge RESET_I) begin
        if (RESET_I) begin
            tx_state  <= T_IDLE;
            tx_sub    <= 4'd0;
            tx_idx    <= 3'd0;
            tx_par_en <= 1'b0;
            tx_stop2  <= 1'b0;
        end else begin
            tx_state  <= tx_state_n;
            tx_sub    <= tx_sub_n;
            tx_idx    <= tx_idx_n;
            tx_par_en <= tx_par_en_n;
            tx_stop2  <= tx_stop2_n;
        end
    end

    always_ff @(posedge CLK_I) begin
        tx_data    <= tx_data_n;
        tx_last    <= tx_last_n;
        tx_par_odd <= tx_par_odd_n;
    end

    always_comb begin
        tx_state_n   = tx_state;
        tx_sub_n     = tx_sub;
        tx_idx_n     = tx_idx;
        tx_last_n    = tx_last;
        tx_data_n    = tx_data;
        tx_par_en_n  = tx_par_en;
        tx_par_odd_n = tx_par_odd;
        tx_stop2_n   = tx_stop2;
        if (tick16) tx_sub_n = tx_sub + 4'd1;
        case (tx_state)
            T_IDLE: begin
                // Sub-bit count restarts at the handshake so every state spans 16 ticks from there.
                tx_sub_n = 4'd0;
                if (TX_VALID_I && TX_READY_O) begin
                    tx_state_n   = T_START;
                    tx_idx_n     = 3'd0;
                    tx_data_n    = TX_DATA_I & (8'hFF >> (2'd3 - CFG_BITS_I));
                    tx_last_n    = 3'd4 + {1'b0, CFG_BITS_I};
                    tx_par_en_n  = cfg_par_en;
                    tx_par_odd_n = cfg_par_odd;
                    tx_stop2_n   = CFG_STOP2_I;
                end
            end
            T_START: if (tx_bit_end) tx_state_n = T_DATA;
            T_DATA: begin
                if (tx_bit_end) begin
                    if (tx_idx == tx_last) tx_state_n = tx_par_en ? T_PAR : T_STOP1;
                    else                   tx_idx_n   = tx_idx + 3'd1;
                end
            end
            T_PAR:   if (tx_bit_end) tx_state_n = T_STOP1;
            T_STOP1: if (tx_bit_end) tx_state_n = tx_stop2 ? T_STOP2 : T_IDLE;
            T_STOP2: if (tx_bit_end) tx_state_n = T_IDLE;
            default: tx_state_n = T_IDLE;
        endcase
    end

    // Line level is decoded from the next state so TX_O leaves a flop in step with the state change.
    always_comb begin
        tx_line_d  = 1'b1;
        tx_ready_d = (tx_state_n == T_IDLE);
        case (tx_state_n)
            T_START: tx_line_d = 1'b0;
            T_DATA:  tx_line_d = tx_data_n[tx_idx_n];
            T_PAR:   tx_line_d = (^tx_data_n) ^ tx_par_odd_n;
            default: tx_line_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK_I or posedge RESET_I) begin
        if (RESET_I) begin
            TX_O       <= 1'b1;
            TX_READY_O <= 1'b0;
        end else begin
            TX_O       <= tx_line_d;
            TX_READY_O <= tx_ready_d;
        end
    end

    // ---------------- receiver input conditioning ----------------
    logic rx_s1, rx_s2, rx_h0, rx_h1, rx_f;

    always_ff @(posedge CLK_I or posedge RESET_I) begin
        if (RESET_I) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_h0 <= 1'b1;
            rx_h1 <= 1'b1;
            rx_f  <= 1'b1;
        end else begin
            rx_s1 <= RX_I;
            rx_s2 <= rx_s1;
            rx_h0 <= rx_s2;
            rx_h1 <= rx_h0;
            if ((rx_s2 == rx_h0) && (rx_h0 == rx_h1)) rx_f <= rx_h1;
        end
    end

    // ---------------- receiver ----------------
    rx_state_t  rx_state, rx_state_n;
    logic [3:0] rx_sub, rx_sub_n;
    logic [2:0] rx_idx, rx_idx_n;
    logic [2:0] rx_last, rx_last_n;
    logic [7:0] rx_shift, rx_shift_n;
    logic       rx_par_en, rx_par_en_n;
    logic       rx_par_odd, rx_par_odd_n;
    logic       rx_par_acc, rx_par_acc_n;
    logic       v7, v8;
    logic       rx_bit, rx_mid, rx_end;
    logic       rx_valid_d, rx_perr_d, rx_ferr_d;

    assign rx_bit = (v7 & v8) | (v7 & rx_f) | (v8 & rx_f);
    assign rx_mid = tick16 && (rx_sub == 4'd9);
    assign rx_end = tick16 && (rx_sub == 4'd15);

    always_ff @(posedge CLK_I or posedge RESET_I) begin
        if (RESET_I) begin
            rx_state  <= R_IDLE;
            rx_sub    <= 4'd0;
            rx_idx    <= 3'd0;
            rx_par_en <= 1'b0;
        end else begin
            rx_state  <= rx_state_n;
            rx_sub    <= rx_sub_n;
            rx_idx    <= rx_idx_n;
            rx_par_en <= rx_par_en_n;
        end
    end

    always_ff @(posedge CLK_I) begin
        rx_last    <= rx_last_n;
        rx_shift   <= rx_shift_n;
        rx_par_odd <= rx_par_odd_n;
        rx_par_acc <= rx_par_acc_n;
        if (tick16 && rx_sub == 4'd7) v7 <= rx_f;
        if (tick16 && rx_sub == 4'd8) v8 <= rx_f;
    end

    always_comb begin
        rx_state_n   = rx_state;
        rx_sub_n     = rx_sub;
        rx_idx_n     = rx_idx;
        rx_last_n    = rx_last;
        rx_shift_n   = rx_shift;
        rx_par_en_n  = rx_par_en;
        rx_par_odd_n = rx_par_odd;
        rx_par_acc_n = rx_par_acc;
        if (tick16) rx_sub_n = rx_sub + 4'd1;
        case (rx_state)
            R_IDLE: begin
                // The detecting tick is sub-sample 0 of the start bit.
                rx_sub_n = 4'd0;
                if (tick16 && !rx_f) begin
                    rx_state_n = R_START;
                    rx_sub_n   = 4'd1;
                end
            end
            R_START: begin
                if (rx_mid) begin
                    if (rx_bit) begin
                        rx_state_n = R_IDLE;
                        rx_sub_n   = 4'd0;
                    end else begin
                        rx_idx_n     = 3'd0;
                        rx_shift_n   = 8'h00;
                        rx_par_acc_n = 1'b0;
                        rx_last_n    = 3'd4 + {1'b0, CFG_BITS_I};
                        rx_par_en_n  = cfg_par_en;
                        rx_par_odd_n = cfg_par_odd;
                    end
                end else if (rx_end) begin
                    rx_state_n = R_DATA;
                end
            end
            R_DATA: begin
                if (rx_mid) begin
                    rx_shift_n[rx_idx] = rx_bit;
                    rx_par_acc_n       = rx_par_acc ^ rx_bit;
                end
                if (rx_end) begin
                    if (rx_idx == rx_last) rx_state_n = rx_par_en ? R_PAR : R_STOP;
                    else                   rx_idx_n   = rx_idx + 3'd1;
                end
            end
            R_PAR: begin
                if (rx_mid) rx_par_acc_n = rx_par_acc ^ rx_bit;
                if (rx_end) rx_state_n = R_STOP;
            end
            R_STOP: begin
                if (rx_mid) begin
                    rx_state_n = rx_bit ? R_IDLE : R_BRK;
                    rx_sub_n   = 4'd0;
                end
            end
            R_BRK: begin
                // Hold off until the line is released so a long break yields a single frame.
                rx_sub_n = 4'd0;
                if (rx_f) rx_state_n = R_IDLE;
            end
            default: rx_state_n = R_IDLE;
        endcase
    end

    always_comb begin
        rx_valid_d = (rx_state == R_STOP) && rx_mid;
        rx_ferr_d  = rx_valid_d && !rx_bit;
        rx_perr_d  = rx_valid_d && rx_par_en && (rx_par_acc ^ rx_par_odd);
    end

    always_ff @(posedge CLK_I or posedge RESET_I) begin
        if (RESET_I) begin
            RX_DATA_O  <= 8'h00;
            RX_VALID_O <= 1'b0;
            RX_PERR_O  <= 1'b0;
            RX_FERR_O  <= 1'b0;
        end else begin
            RX_VALID_O <= rx_valid_d;
            RX_PERR_O  <= rx_perr_d;
            RX_FERR_O  <= rx_ferr_d;
            if (rx_valid_d) RX_DATA_O <= rx_shift;
        end
    end

endmodule
